// File: rtl/ysyx_22050598_trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap sequencer: cause codes,
// mstatus/mie bit positions, sequencer states and event kinds.
package ysyx_22050598_trap_ctrl_pkg;

  localparam int CODE_W = 4;

  // mcause exception / interrupt codes
  localparam logic [CODE_W-1:0] CAUSE_ECALL_M = 4'd11;
  localparam logic [CODE_W-1:0] IRQ_MSI       = 4'd3;
  localparam logic [CODE_W-1:0] IRQ_MTI       = 4'd7;
  localparam logic [CODE_W-1:0] IRQ_MEI       = 4'd11;

  // The interrupt flag lives in the MSB of mcause, whatever XLEN is
  localparam int CAUSE_IRQ_FROM_MSB = 0;

  // mstatus bit positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // mie enable bit positions
  localparam int MIE_MSIE = 3;
  localparam int MIE_MTIE = 7;
  localparam int MIE_MEIE = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_WRITE = 2'd2,
    ST_REDIR = 2'd3
  } trap_state_e;

  typedef enum logic [1:0] {
    EV_NONE  = 2'd0,
    EV_ECALL = 2'd1,
    EV_MRET  = 2'd2,
    EV_IRQ   = 2'd3
  } trap_kind_e;

endpackage

// File: rtl/ysyx_22050598_trap_ctrl_if.sv
// Trap interface between the commit point, CSR file and IFU. The trap
// sequencer is the master; the surrounding pipeline is the slave.
interface ysyx_22050598_trap_ctrl_if #(
  parameter int XLEN = 64
);
  logic            commit_valid_i;
  logic [XLEN-1:0] commit_pc_i;
  logic [XLEN-1:0] commit_npc_i;
  logic            commit_is_ecall_i;
  logic            commit_is_mret_i;
  logic            irq_meip_i;
  logic            irq_msip_i;
  logic            irq_mtip_i;
  logic [XLEN-1:0] csr_mstatus_i;
  logic [XLEN-1:0] csr_mie_i;
  logic [XLEN-1:0] csr_mtvec_i;
  logic [XLEN-1:0] csr_mepc_i;
  logic            drain_done_i;
  logic            redirect_ready_i;

  logic            stall_o;
  logic            flush_o;
  logic            csr_wen_o;
  logic [XLEN-1:0] csr_mepc_o;
  logic [XLEN-1:0] csr_mcause_o;
  logic [XLEN-1:0] csr_mstatus_o;
  logic            csr_trap_o;
  logic            redirect_valid_o;
  logic [XLEN-1:0] redirect_pc_o;

  modport master (
    input  commit_valid_i, commit_pc_i, commit_npc_i, commit_is_ecall_i,
           commit_is_mret_i, irq_meip_i, irq_msip_i, irq_mtip_i,
           csr_mstatus_i, csr_mie_i, csr_mtvec_i, csr_mepc_i,
           drain_done_i, redirect_ready_i,
    output stall_o, flush_o, csr_wen_o, csr_mepc_o, csr_mcause_o,
           csr_mstatus_o, csr_trap_o, redirect_valid_o, redirect_pc_o
  );

  modport slave (
    output commit_valid_i, commit_pc_i, commit_npc_i, commit_is_ecall_i,
           commit_is_mret_i, irq_meip_i, irq_msip_i, irq_mtip_i,
           csr_mstatus_i, csr_mie_i, csr_mtvec_i, csr_mepc_i,
           drain_done_i, redirect_ready_i,
    input  stall_o, flush_o, csr_wen_o, csr_mepc_o, csr_mcause_o,
           csr_mstatus_o, csr_trap_o, redirect_valid_o, redirect_pc_o
  );
endinterface

// File: rtl/ysyx_22050598_sirv_gnrl_dfflr.sv
// General-purpose load-enabled flop with synchronous active-high reset.
module ysyx_22050598_sirv_gnrl_dfflr #(
  parameter int DW = 32
) (
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout,
  input  logic          clk,
  input  logic          rst
);

  // Capture dnxt when lden is set, clear on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      qout <= '0;
    end else if (lden) begin
      qout <= dnxt;
    end
  end

endmodule

// File: rtl/ysyx_22050598_trap_prio.sv
// Fixed-priority machine interrupt selector: MEI > MSI > MTI.
module ysyx_22050598_trap_prio
  import ysyx_22050598_trap_ctrl_pkg::*;
(
  input  logic [2:0]        pend,   // {meip, msip, mtip}
  input  logic [2:0]        en,     // {meie, msie, mtie}
  output logic              taken,
  output logic [CODE_W-1:0] code
);

  logic [2:0] act;

  // Mask pending lines with their enables and pick the highest priority
  always_comb begin
    act   = pend & en;
    taken = |act;
    code  = '0;
    if (act[2]) begin
      code = IRQ_MEI;
    end else if (act[1]) begin
      code = IRQ_MSI;
    end else if (act[0]) begin
      code = IRQ_MTI;
    end
  end

endmodule

// File: rtl/ysyx_22050598_trap_ctrl.sv
// Machine-mode trap sequencer: decides ecall / mret / interrupt at commit,
// then flushes, writes the trap CSRs and redirects fetch.
module ysyx_22050598_trap_ctrl
  import ysyx_22050598_trap_ctrl_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter bit VEC_EN = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  ysyx_22050598_trap_ctrl_if.master  bus
);

  trap_state_e       state, state_nxt;

  logic              irq_taken;
  logic [CODE_W-1:0] irq_code;

  logic              take;
  trap_kind_e        kind_nxt;
  logic [XLEN-1:0]   cause_nxt;
  logic [XLEN-1:0]   epc_nxt;

  logic [1:0]        kind_raw;
  trap_kind_e        kind_q;
  logic [XLEN-1:0]   cause_q;
  logic [XLEN-1:0]   epc_q;
  logic [XLEN-1:0]   mstatus_q;
  logic [XLEN-1:0]   mtvec_q;
  logic [XLEN-1:0]   mepc_q;

  logic [XLEN-1:0]   target;
  logic [XLEN-1:0]   base;

  logic              stall_q;
  logic              flush_q;
  logic              wen_q;
  logic              trap_q;
  logic              rvalid_q;
  logic [XLEN-1:0]   out_mepc_q;
  logic [XLEN-1:0]   out_mcause_q;
  logic [XLEN-1:0]   out_mstatus_q;
  logic [XLEN-1:0]   rpc_q;

  logic              unused_bits;

  function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] x);
    return {x[XLEN-1:2], 2'b00};
  endfunction

  function automatic logic [XLEN-1:0] irq_cause(input logic [CODE_W-1:0] c);
    logic [XLEN-1:0] r;
    r = '0;
    r[XLEN-1-CAUSE_IRQ_FROM_MSB] = 1'b1;
    r[CODE_W-1:0] = c;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  ysyx_22050598_trap_prio u_prio (
    .pend  ({bus.irq_meip_i, bus.irq_msip_i, bus.irq_mtip_i}),
    .en    ({bus.csr_mie_i[MIE_MEIE], bus.csr_mie_i[MIE_MSIE], bus.csr_mie_i[MIE_MTIE]}),
    .taken (irq_taken),
    .code  (irq_code)
  );

  // Commit-time decision: ecall beats mret beats an enabled interrupt
  always_comb begin
    take      = 1'b0;
    kind_nxt  = EV_NONE;
    cause_nxt = '0;
    epc_nxt   = '0;
    if (state == ST_IDLE && bus.commit_valid_i) begin
      if (bus.commit_is_ecall_i) begin
        take      = 1'b1;
        kind_nxt  = EV_ECALL;
        cause_nxt = XLEN'(CAUSE_ECALL_M);
        epc_nxt   = bus.commit_pc_i;
      end else if (bus.commit_is_mret_i) begin
        take      = 1'b1;
        kind_nxt  = EV_MRET;
      end else if (bus.csr_mstatus_i[MSTATUS_MIE] && irq_taken) begin
        take      = 1'b1;
        kind_nxt  = EV_IRQ;
        cause_nxt = irq_cause(irq_code);
        epc_nxt   = bus.commit_npc_i;
      end
    end
  end

  // Event and CSR snapshots are frozen for the whole sequence
  ysyx_22050598_sirv_gnrl_dfflr #(.DW(2)) u_kind (
    .lden(take), .dnxt(kind_nxt), .qout(kind_raw), .clk(clk), .rst(rst));
  ysyx_22050598_sirv_gnrl_dfflr #(.DW(XLEN)) u_cause (
    .lden(take), .dnxt(cause_nxt), .qout(cause_q), .clk(clk), .rst(rst));
  ysyx_22050598_sirv_gnrl_dfflr #(.DW(XLEN)) u_epc (
    .lden(take), .dnxt(epc_nxt), .qout(epc_q), .clk(clk), .rst(rst));
  ysyx_22050598_sirv_gnrl_dfflr #(.DW(XLEN)) u_mstatus (
    .lden(take), .dnxt(bus.csr_mstatus_i), .qout(mstatus_q), .clk(clk), .rst(rst));
  ysyx_22050598_sirv_gnrl_dfflr #(.DW(XLEN)) u_mtvec (
    .lden(take), .dnxt(bus.csr_mtvec_i), .qout(mtvec_q), .clk(clk), .rst(rst));
  ysyx_22050598_sirv_gnrl_dfflr #(.DW(XLEN)) u_mepc (
    .lden(take), .dnxt(bus.csr_mepc_i), .qout(mepc_q), .clk(clk), .rst(rst));

  assign kind_q = trap_kind_e'(kind_raw);

  // Redirect target: mepc for mret, mtvec base (optionally vectored) for traps
  always_comb begin
    base   = align4(mtvec_q);
    target = base;
    if (kind_q == EV_MRET) begin
      target = align4(mepc_q);
    end else if (VEC_EN && mtvec_q[1:0] == 2'b01 && kind_q == EV_IRQ) begin
      target = base + (XLEN'(cause_q[CODE_W-1:0]) << 2);
    end
  end

  // Sequencer next-state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (take) state_nxt = ST_FLUSH;
      ST_FLUSH: if (bus.drain_done_i) state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = ST_REDIR;
      ST_REDIR: if (bus.redirect_ready_i) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered outputs derived from the upcoming state
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q       <= 1'b0;
      flush_q       <= 1'b0;
      wen_q         <= 1'b0;
      trap_q        <= 1'b0;
      rvalid_q      <= 1'b0;
      out_mepc_q    <= '0;
      out_mcause_q  <= '0;
      out_mstatus_q <= '0;
      rpc_q         <= '0;
    end else begin
      stall_q  <= (state_nxt != ST_IDLE);
      flush_q  <= (state_nxt == ST_FLUSH);
      wen_q    <= (state_nxt == ST_WRITE);
      trap_q   <= (state_nxt == ST_WRITE) && (kind_q != EV_MRET);
      rvalid_q <= (state_nxt == ST_REDIR);
      if (state == ST_FLUSH && state_nxt == ST_WRITE) begin
        if (kind_q == EV_MRET) begin
          out_mepc_q    <= '0;
          out_mcause_q  <= '0;
          out_mstatus_q <= mret_mstatus(mstatus_q);
        end else begin
          out_mepc_q    <= align4(epc_q);
          out_mcause_q  <= cause_q;
          out_mstatus_q <= trap_mstatus(mstatus_q);
        end
      end
      if (state == ST_WRITE) begin
        rpc_q <= target;
      end
    end
  end

  assign bus.stall_o          = stall_q;
  assign bus.flush_o          = flush_q;
  assign bus.csr_wen_o        = wen_q;
  assign bus.csr_trap_o       = trap_q;
  assign bus.csr_mepc_o       = out_mepc_q;
  assign bus.csr_mcause_o     = out_mcause_q;
  assign bus.csr_mstatus_o    = out_mstatus_q;
  assign bus.redirect_valid_o = rvalid_q;
  assign bus.redirect_pc_o    = rpc_q;

  assign unused_bits = ^{bus.csr_mie_i, epc_q[1:0], mepc_q[1:0]};

endmodule

// File: doc/ysyx_22050598_trap_ctrl.md
Name: ysyx_22050598_trap_ctrl

Overview:
Machine-mode trap sequencer. It is the initiator side of the execute-stage CSR unit's trap interface. At instruction commit it decides whether to take an ecall, an interrupt or an mret, then runs a multi-cycle sequence:
- flush the pipeline,
- drive the mepc/mcause/mstatus write strobes into the CSR file,
- hand a redirect PC to the IFU with a valid/ready handshake.

It sits between the commit point of the EXU/WBU and the CSR file and IFU.

Parameters:
XLEN, 64, data/PC width
VEC_EN, 1, 1 = honour mtvec.MODE==1 (vectored) for interrupts; 0 = always direct

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
commit_valid_i  in  1  one instruction commits this cycle
commit_pc_i  in  XLEN  PC of committing instruction
commit_npc_i  in  XLEN  PC of next sequential/branch target
commit_is_ecall_i  in  1  committing instruction is ecall
commit_is_mret_i  in  1  committing instruction is mret
irq_meip_i  in  1  external interrupt pending
irq_msip_i  in  1  software interrupt pending
irq_mtip_i  in  1  timer interrupt pending
csr_mstatus_i  in  XLEN  current mstatus (MIE bit3, MPIE bit7)
csr_mie_i  in  XLEN  current mie (MEIE 11, MSIE 3, MTIE 7)
csr_mtvec_i  in  XLEN  current mtvec
csr_mepc_i  in  XLEN  current mepc
drain_done_i  in  1  pipeline empty after flush
redirect_ready_i  in  1  IFU accepts redirect
stall_o  out  1  hold commit/upstream stages
flush_o  out  1  kill all in-flight instructions
csr_wen_o  out  1  one-cycle CSR write strobe
csr_mepc_o  out  XLEN  value for mepc (valid with csr_wen_o on trap)
csr_mcause_o  out  XLEN  value for mcause
csr_mstatus_o  out  XLEN  value for mstatus
csr_trap_o  out  1  qualifies csr_wen_o: 1 = trap entry (write mepc, mcause, mstatus), 0 = mret (write mstatus only)
redirect_valid_o  out  1  redirect PC valid
redirect_pc_o  out  XLEN  new fetch PC

Behaviour:
- All outputs are registered. On reset: state IDLE, every output 0.
- States: IDLE, FLUSH, WRITE, REDIR.

IDLE decision, evaluated only when commit_valid_i=1, in priority order:
1. ecall: cause=11, epc=commit_pc_i, trap.
2. mret: trap=0.
3. Interrupt, only if mstatus[3]=1 and (irq & mie) != 0. Priority MEI(11) > MSI(3) > MTI(7). Cause = {1'b1, 59'b0, code}, epc=commit_npc_i.
4. Otherwise stay in IDLE.

Taking a decision:
- Latch cause, epc and the kind of event.
- Snapshot mstatus, mtvec and mepc.
- Next cycle: state FLUSH, flush_o=1, stall_o=1.
- ecall+mret in the same commit is impossible; ecall wins if asserted.
- An ecall or mret is never masked by MIE.

FLUSH:
- flush_o stays high until drain_done_i=1. drain_done_i may already be 1 on the first cycle.
- Then go to WRITE with flush_o=0.

WRITE (exactly 1 cycle, csr_wen_o=1):
- Trap entry: csr_mepc_o = epc with bits[1:0] cleared; csr_mcause_o = cause; csr_mstatus_o = snapshot with MPIE<-MIE, MIE<-0, MPP[12:11]<-2'b11.
- mret: csr_mstatus_o = snapshot with MIE<-MPIE, MPIE<-1, MPP<-2'b11.
- Go to REDIR.

REDIR:
- redirect_valid_o=1, with redirect_pc_o held stable until redirect_ready_i=1.
- Redirect target:
  - Trap: base = {mtvec[XLEN-1:2], 2'b00}. If VEC_EN and mtvec[1:0]==2'b01 and the event is an interrupt, target = base + 4*code (addition wraps at XLEN). Otherwise target = base.
  - mret: target = the snapshotted mepc with bits[1:0] cleared.
- On the handshake, next cycle is IDLE, redirect_valid_o=0, stall_o=0.
- If redirect_ready_i=1 on the first REDIR cycle, redirect_valid_o is high for exactly one cycle.

Other rules:
- stall_o=1 in every state except IDLE.
- Commit inputs and interrupt lines are ignored outside IDLE; an interrupt that deasserts mid-sequence does not abort it.
- Interrupts are re-evaluated only at the next commit in IDLE. Since MIE=0 after trap entry, there is no immediate re-entry.
- rst in any state returns to IDLE in the next cycle: no CSR write, no redirect, outputs 0.

Decomposition:
- Shared defines file: mcause codes (ECALL_M=11, MSI=3, MTI=7, MEI=11), the interrupt flag bit, mstatus bit positions (MIE=3, MPIE=7, MPP=12:11), and the state encodings.
- Use the existing ysyx_22050598_sirv_gnrl_dfflr for the latched epc, cause and kind registers.
- One combinational sub-module, ysyx_22050598_trap_prio: pending vector plus enables in, taken flag and code out.

Test Plan:
1. ecall commit at pc=0x8000_0100, mtvec=0x8000_1000, mstatus=0x8:
   - flush_o for 1 cycle (drain_done_i=1);
   - csr_wen_o=1, csr_trap_o=1 with mepc=0x8000_0100, mcause=0xB, mstatus=0x1880;
   - redirect_pc_o=0x8000_1000.
2. mret with mepc=0x8000_0104, mstatus=0x1880:
   - csr_wen_o=1, csr_trap_o=0, csr_mstatus_o=0x1888;
   - redirect_pc_o=0x8000_0104.
3. mtip=1, mie=0x80, MIE=1, commit npc=0x8000_0204, mtvec=0x8000_1001 (vectored):
   - mcause=0x8000_0000_0000_0007, mepc=0x8000_0204;
   - redirect_pc_o=0x8000_101C.
4. meip, msip and mtip all pending with all enabled:
   - mcause code 11 is taken.
   - Repeat with MIE=0: no trap, stall_o stays 0.
5. Handshake timing:
   - redirect_ready_i held 0 for 3 cycles: redirect_valid_o and redirect_pc_o stay stable; stall_o=1 throughout.
   - drain_done_i delayed 4 cycles: flush_o stays high for 4 cycles.
6. rst asserted during FLUSH:
   - next cycle all outputs 0, state IDLE;
   - no csr_wen_o pulse ever seen.
